// File: rtl/rx_word_aligner.sv
// rx_word_aligner: bitslip-driven word aligner that locks onto TRAIN_PATTERN once the receiver is initialised.
// Optional macro RX_ALIGN_RETRY_EN: FAIL re-arms itself after RETRY_WAIT cycles instead of holding align_fail.
module rx_word_aligner #(
   parameter int                      DESER_FACTOR  = 10,
   parameter logic [DESER_FACTOR-1:0] TRAIN_PATTERN = 10'h3F0,
   parameter int                      MATCH_COUNT   = 16,
   parameter int                      SLIP_SETTLE   = 4,
   parameter int                      RETRY_WAIT    = 64
) (
   input  logic                              inclock,
   input  logic                              areset_n,
   input  logic                              init_done,
   input  logic                              restart,
   input  logic [DESER_FACTOR-1:0]           rx_data_in,
   output logic                              rx_data_align,
   output logic                              aligned,
   output logic                              align_fail,
   output logic [$clog2(DESER_FACTOR+1)-1:0] slip_count,
   output logic [DESER_FACTOR-1:0]           data_out,
   output logic                              data_valid
);

   localparam int SCW = $clog2(DESER_FACTOR+1);
   localparam int MCW = $clog2(MATCH_COUNT+1);
   localparam int TCW = $clog2(SLIP_SETTLE+1);
   localparam logic [SCW-1:0] SLIP_LAST   = SCW'(DESER_FACTOR-1);
   localparam logic [MCW-1:0] MATCH_LAST  = MCW'(MATCH_COUNT-1);
   localparam logic [TCW-1:0] SETTLE_LAST = TCW'(SLIP_SETTLE-1);

   if (MATCH_COUNT < 1 || SLIP_SETTLE < 1 || RETRY_WAIT < 1) begin : g_param_check
      $error("rx_word_aligner: MATCH_COUNT, SLIP_SETTLE and RETRY_WAIT must all be >= 1");
   end

   typedef enum logic [2:0] {IDLE, CHECK, SLIP, SETTLE, LOCKED, FAIL} state_t;

   state_t                  state, state_nxt;
   logic [DESER_FACTOR-1:0] rx_data_p0;
   logic [MCW-1:0]          match_cnt, match_nxt;
   logic [SCW-1:0]          slip_nxt;
   logic [TCW-1:0]          settle_cnt, settle_nxt;
   logic                    align_fail_nxt;
`ifdef RX_ALIGN_RETRY_EN
   localparam int RCW = $clog2(RETRY_WAIT+1);
   localparam logic [RCW-1:0] RETRY_LAST = RCW'(RETRY_WAIT-1);
   logic [RCW-1:0]          retry_cnt, retry_nxt;
`endif

   // stage p0: input word capture, all pattern comparisons use this register
   always_ff @(posedge inclock) begin
      rx_data_p0 <= rx_data_in;
   end

   always_comb begin
      state_nxt      = state;
      match_nxt      = match_cnt;
      slip_nxt       = slip_count;
      settle_nxt     = settle_cnt;
      align_fail_nxt = 1'b0;
`ifdef RX_ALIGN_RETRY_EN
      retry_nxt      = retry_cnt;
`endif
      case (state)
         IDLE: begin
            if (init_done) state_nxt = CHECK;
         end
         CHECK: begin
            if (rx_data_p0 == TRAIN_PATTERN) begin
               match_nxt = match_cnt + 1'b1;
               if (match_cnt == MATCH_LAST) state_nxt = LOCKED;
            end else begin
               match_nxt = '0;
               if (slip_count == SLIP_LAST) begin
                  state_nxt = FAIL;
`ifdef RX_ALIGN_RETRY_EN
                  retry_nxt = '0;
`endif
               end else begin
                  state_nxt = SLIP;
                  slip_nxt  = slip_count + 1'b1;
               end
            end
         end
         SLIP: begin
            state_nxt  = SETTLE;
            settle_nxt = '0;
         end
         SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
               state_nxt = CHECK;
               match_nxt = '0;
            end else begin
               settle_nxt = settle_cnt + 1'b1;
            end
         end
         LOCKED: begin
            if (restart) state_nxt = IDLE;
         end
         FAIL: begin
            if (restart) begin
               state_nxt = IDLE;
            end
`ifdef RX_ALIGN_RETRY_EN
            else if (retry_cnt == RETRY_LAST) begin
               state_nxt = CHECK;
               slip_nxt  = '0;
               match_nxt = '0;
            end else begin
               retry_nxt = retry_cnt + 1'b1;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase

      // losing init_done overrides every decision made above
      if (!init_done) state_nxt = IDLE;

      if (state_nxt == IDLE) begin
         match_nxt  = '0;
         slip_nxt   = '0;
         settle_nxt = '0;
`ifdef RX_ALIGN_RETRY_EN
         retry_nxt  = '0;
`endif
      end

`ifdef RX_ALIGN_RETRY_EN
      align_fail_nxt = (state_nxt == FAIL) && (state != FAIL);
`else
      align_fail_nxt = (state_nxt == FAIL);
`endif
   end

   // stage p1: state, counters and registered outputs
   always_ff @(posedge inclock or negedge areset_n) begin
      if (!areset_n) begin
         state         <= IDLE;
         match_cnt     <= '0;
         slip_count    <= '0;
         settle_cnt    <= '0;
         rx_data_align <= 1'b0;
         aligned       <= 1'b0;
         data_valid    <= 1'b0;
         align_fail    <= 1'b0;
         data_out      <= '0;
      end else begin
         state         <= state_nxt;
         match_cnt     <= match_nxt;
         slip_count    <= slip_nxt;
         settle_cnt    <= settle_nxt;
         rx_data_align <= (state_nxt == SLIP);
         aligned       <= (state_nxt == LOCKED);
         data_valid    <= (state_nxt == LOCKED);
         align_fail    <= align_fail_nxt;
         data_out      <= (state_nxt == LOCKED) ? rx_data_p0 : '0;
      end
   end

`ifdef RX_ALIGN_RETRY_EN
   always_ff @(posedge inclock or negedge areset_n) begin
      if (!areset_n) retry_cnt <= '0;
      else           retry_cnt <= retry_nxt;
   end
`endif

endmodule

// File: tb/tb_rx_word_aligner.sv
// Testbench for rx_word_aligner: table vectors, hand-written corner sequences and randomised offsets
// checked against an arithmetic model of the bitslip search, with a rotating deserializer model.
module tb_rx_word_aligner;

   localparam int DF = 10;
   localparam logic [DF-1:0] PAT   = 10'h3F0;
   localparam logic [DF-1:0] NOPAT = 10'h155;
   localparam int MC = 16;
   localparam int SS = 4;
   localparam int RW = 64;

   logic          inclock = 1'b0;
   logic          areset_n, init_done, restart;
   logic [DF-1:0] rx_data_in;
   logic          rx_data_align, aligned, align_fail, data_valid;
   logic [3:0]    slip_count;
   logic [DF-1:0] data_out;

   rx_word_aligner #(
      .DESER_FACTOR(DF), .TRAIN_PATTERN(PAT), .MATCH_COUNT(MC),
      .SLIP_SETTLE(SS), .RETRY_WAIT(RW)
   ) dut (
      .inclock(inclock), .areset_n(areset_n), .init_done(init_done), .restart(restart),
      .rx_data_in(rx_data_in), .rx_data_align(rx_data_align), .aligned(aligned),
      .align_fail(align_fail), .slip_count(slip_count), .data_out(data_out),
      .data_valid(data_valid)
   );

   always #5 inclock = ~inclock;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int mis    = 0;
   bit use_model = 1'b1;
   bit present   = 1'b1;
   int pulses[$];
   logic [DF-1:0] hist[$];

   typedef struct {
      int mis;
      bit present;
      int exp_pulses;
      int exp_slip;
      bit exp_aligned;
      bit exp_fail;
      int exp_cyc;
   } vec_t;
   vec_t vecs[5];

   function automatic logic [DF-1:0] rotl(input logic [DF-1:0] w, input int k);
      logic [DF-1:0] r;
      r = w;
      for (int i = 0; i < k; i++) r = {r[DF-2:0], r[DF-1]};
      return r;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic drive_data();
      if (use_model) rx_data_in = present ? rotl(PAT, mis) : NOPAT;
   endtask

   // deserializer model: each bitslip pulse moves the word boundary one bit toward alignment
   task automatic step();
      @(posedge inclock);
      #1;
      cyc++;
      if (rx_data_align) begin
         pulses.push_back(cyc);
         mis = (mis + DF - 1) % DF;
      end
      drive_data();
   endtask

   // pulse k (0-based) of an attempt lands (SS+2) cycles after the previous, the first one cycle into CHECK
   function automatic int pulses_match_model(input int m);
      if (pulses.size() != m) return 0;
      for (int k = 0; k < m; k++)
         if (pulses[k] != 2 + k * (SS + 2)) return 0;
      return 1;
   endfunction

   function automatic int gaps_ok();
      for (int k = 1; k < pulses.size(); k++)
         if (pulses[k] - pulses[k-1] < SS + 1) return 0;
      return 1;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_align_pulse"}, int'(rx_data_align), 0);
      check({tag, "_aligned"},     int'(aligned), 0);
      check({tag, "_align_fail"},  int'(align_fail), 0);
      check({tag, "_slip_count"},  int'(slip_count), 0);
      check({tag, "_data_valid"},  int'(data_valid), 0);
      check({tag, "_data_out"},    int'(data_out), 0);
   endtask

   task automatic start_attempt(input int m, input bit pres);
      init_done = 1'b0;
      restart   = 1'b0;
      step();
      step();
      use_model = 1'b1;
      mis       = m;
      present   = pres;
      drive_data();
      pulses.delete();
      step();
      init_done = 1'b1;
      cyc       = 0;
   endtask

   task automatic run_attempt(input int budget, output int done_cyc);
      int n;
      n = 0;
      done_cyc = -1;
      while (done_cyc < 0 && n < budget) begin
         step();
         n++;
         if (aligned || align_fail) done_cyc = cyc;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int done;
      int m;

      vecs[0] = '{0, 1'b1, 0, 0, 1'b1, 1'b0, 17};
      vecs[1] = '{3, 1'b1, 3, 3, 1'b1, 1'b0, 35};
      vecs[2] = '{9, 1'b1, 9, 9, 1'b1, 1'b0, 71};
      vecs[3] = '{0, 1'b0, 9, 9, 1'b0, 1'b1, 56};
      vecs[4] = '{5, 1'b1, 5, 5, 1'b1, 1'b0, 47};

      areset_n   = 1'b0;
      init_done  = 1'b0;
      restart    = 1'b0;
      rx_data_in = '0;
      #1;
      check_idle("reset");
      #12;
      areset_n = 1'b1;
      step();

      // table-driven alignment attempts
      for (int i = 0; i < 5; i++) begin
         start_attempt(vecs[i].mis, vecs[i].present);
         run_attempt(200, done);
         check($sformatf("vec%0d_done_cycle", i), done, vecs[i].exp_cyc);
         check($sformatf("vec%0d_aligned", i), int'(aligned), int'(vecs[i].exp_aligned));
         check($sformatf("vec%0d_data_valid", i), int'(data_valid), int'(vecs[i].exp_aligned));
         check($sformatf("vec%0d_align_fail", i), int'(align_fail), int'(vecs[i].exp_fail));
         check($sformatf("vec%0d_slip_count", i), int'(slip_count), vecs[i].exp_slip);
         check($sformatf("vec%0d_pulse_times", i), pulses_match_model(vecs[i].exp_pulses), 1);
         check($sformatf("vec%0d_data_out", i), int'(data_out),
               vecs[i].exp_aligned ? int'(PAT) : 0);
      end

      // pattern absent: behaviour after FAIL
      start_attempt(0, 1'b0);
      run_attempt(200, done);
      check("absent_fail_cycle", done, 56);
`ifndef RX_ALIGN_RETRY_EN
      repeat (10) step();
      check("fail_sticky", int'(align_fail), 1);
      check("fail_not_aligned", int'(aligned), 0);
      check("fail_slip_hold", int'(slip_count), 9);
      check("fail_no_more_pulses", pulses.size(), 9);
      restart = 1'b1;
      step();
      restart = 1'b0;
      check("restart_from_fail_clear", int'(align_fail), 0);
      check("restart_from_fail_slip", int'(slip_count), 0);
      step();
      check("restart_check_no_pulse", int'(rx_data_align), 0);
      step();
      check("restart_resumes_slip", int'(rx_data_align), 1);
      check("restart_slip_count", int'(slip_count), 1);
`else
      step();
      check("retry_fail_pulse_width", int'(align_fail), 0);
      check("retry_slip_hold", int'(slip_count), 9);
      repeat (RW - 1) step();
      check("retry_wait_no_pulse", pulses.size(), 9);
      check("retry_slip_cleared", int'(slip_count), 0);
      step();
      check("retry_resumes_slip", int'(rx_data_align), 1);
      check("retry_slip_count", int'(slip_count), 1);
`endif

      // 15 matches then a mismatch; restart during SETTLE must be ignored
      init_done = 1'b0;
      step();
      step();
      use_model  = 1'b0;
      rx_data_in = PAT;
      pulses.delete();
      step();
      init_done = 1'b1;
      cyc       = 0;
      repeat (15) step();
      check("m15_not_locked", int'(aligned), 0);
      rx_data_in = rotl(PAT, 1);
      step();
      rx_data_in = PAT;
      check("m15_no_pulse_yet", int'(rx_data_align), 0);
      step();
      check("m15_mismatch_pulse", int'(rx_data_align), 1);
      check("m15_slip_count", int'(slip_count), 1);
      check("m15_still_unaligned", int'(aligned), 0);
      repeat (2) step();
      restart = 1'b1;
      step();
      restart = 1'b0;
      repeat (17) step();
      check("m15_relock_not_early", int'(aligned), 0);
      step();
      check("m15_relock", int'(aligned), 1);
      check("m15_single_pulse", pulses.size(), 1);

      // init_done dropped during SETTLE
      start_attempt(3, 1'b1);
      repeat (3) step();
      check("settle_first_pulse", pulses.size(), 1);
      init_done = 1'b0;
      step();
      check_idle("settle_drop");
      repeat (20) step();
      check("settle_drop_no_pulse", pulses.size(), 1);
      check("settle_drop_stays_idle", int'(aligned), 0);

      // init_done drop together with restart in LOCKED
      start_attempt(0, 1'b1);
      run_attempt(100, done);
      check("lock_before_drop", int'(aligned), 1);
      init_done = 1'b0;
      restart   = 1'b1;
      step();
      restart = 1'b0;
      check_idle("locked_drop");
      repeat (5) step();
      check("locked_drop_no_pulse", pulses.size(), 0);

      // restart alone in LOCKED re-runs alignment
      start_attempt(2, 1'b1);
      run_attempt(100, done);
      check("pre_restart_lock_cycle", done, 2 * (SS + 2) + MC + 1);
      restart = 1'b1;
      step();
      restart = 1'b0;
      check("restart_locked_unaligned", int'(aligned), 0);
      check("restart_locked_slip", int'(slip_count), 0);
      cyc = 0;
      run_attempt(100, done);
      check("restart_relock_cycle", done, MC + 1);
      check("restart_relock_no_pulse", pulses.size(), 2);

      // randomised initial offsets
      for (int t = 0; t < 6; t++) begin
         m = int'($urandom_range(0, DF - 1));
         start_attempt(m, 1'b1);
         run_attempt(200, done);
         check($sformatf("rnd%0d_off%0d_cycle", t, m), done, m * (SS + 2) + MC + 1);
         check($sformatf("rnd%0d_off%0d_slip", t, m), int'(slip_count), m);
         check($sformatf("rnd%0d_off%0d_pulses", t, m), pulses_match_model(m), 1);
         check($sformatf("rnd%0d_off%0d_gaps", t, m), gaps_ok(), 1);
      end

      // locked data path with random words, then async reset mid-LOCKED
      start_attempt(7, 1'b1);
      run_attempt(200, done);
      check("burst_lock_cycle", done, 7 * (SS + 2) + MC + 1);
      check("burst_slip_count", int'(slip_count), 7);
      use_model = 1'b0;
      hist.delete();
      for (int i = 0; i < 24; i++) begin
         rx_data_in = DF'($urandom);
         hist.push_back(rx_data_in);
         step();
         if (hist.size() == 2) check($sformatf("burst_data_out_%0d", i), int'(data_out), int'(hist.pop_front()));
      end
      check("burst_still_aligned", int'(aligned), 1);
      check("burst_data_valid", int'(data_valid), 1);
      #3;
      areset_n = 1'b0;
      #1;
      check_idle("async_reset");
      #2;
      areset_n  = 1'b1;
      use_model = 1'b1;
      present   = 1'b1;
      mis       = 0;
      drive_data();
      pulses.delete();
      cyc = 0;
      run_attempt(100, done);
      check("post_reset_relock_cycle", done, MC + 1);
      check("post_reset_slip", int'(slip_count), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
